// File: rtl/regfile_context_engine_if.sv
// Bus bundle between the context engine, the register file and the
// save/restore streams. The engine owns the master side; the environment
// (register file plus stream partners) owns the slave side.
interface regfile_context_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // Control and status
    logic                  SaveStart;
    logic                  RestoreStart;
    logic                  Busy;
    logic                  Done;

    // Register file read port
    logic [ADDR_WIDTH-1:0] ReadRegister;
    logic [DATA_WIDTH-1:0] ReadData;

    // Register file write port
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;

    // Save stream (engine -> consumer)
    logic [DATA_WIDTH-1:0] OutData;
    logic                  OutValid;
    logic                  OutReady;

    // Restore stream (producer -> engine)
    logic [DATA_WIDTH-1:0] InData;
    logic                  InValid;
    logic                  InReady;

    modport master (
        input  SaveStart, RestoreStart, ReadData, OutReady, InData, InValid,
        output Busy, Done, ReadRegister, WriteRegister, WriteData, RegWrite,
               OutData, OutValid, InReady
    );

    modport slave (
        output SaveStart, RestoreStart, ReadData, OutReady, InData, InValid,
        input  Busy, Done, ReadRegister, WriteRegister, WriteData, RegWrite,
               OutData, OutValid, InReady
    );
endinterface

// File: rtl/regfile_context_engine.sv
// Register file context engine: streams registers FIRST_REG..LAST_REG out of
// the register file (save) or streams them back in (restore), one word per
// handshake. Outputs are decoded purely from the current state so that an
// asynchronous reset silences every output without waiting for a clock edge.
module regfile_context_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIRST_REG  = 1,
    parameter int LAST_REG   = 31
) (
    input  logic                         Clk,
    input  logic                         Reset,
    regfile_context_engine_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(FIRST_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(LAST_REG);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;

    // Decoded outputs, collected here before being placed on the bus
    logic                  busy_c;
    logic                  done_c;
    logic [ADDR_WIDTH-1:0] read_register_c;
    logic [ADDR_WIDTH-1:0] write_register_c;
    logic [DATA_WIDTH-1:0] write_data_c;
    logic                  reg_write_c;
    logic [DATA_WIDTH-1:0] out_data_c;
    logic                  out_valid_c;
    logic                  in_ready_c;

    // State and index registers; reset aborts any transfer immediately
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= FIRST_IDX;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state and index: advance on each handshake, finish after LAST_REG
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = FIRST_IDX;
                // Save has priority when both requests arrive together
                if (bus.SaveStart) begin
                    state_d = ST_SAVE;
                end else if (bus.RestoreStart) begin
                    state_d = ST_RESTORE;
                end
            end
            ST_SAVE: begin
                // OutValid is always high here, so OutReady alone is the handshake
                if (bus.OutReady) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_RESTORE: begin
                // InReady is always high here, so InValid alone is the handshake
                if (bus.InValid) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                idx_d   = FIRST_IDX;
                state_d = ST_IDLE;
            end
            default: begin
                idx_d   = FIRST_IDX;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from state; everything is zero outside its owning state
    always_comb begin
        busy_c           = 1'b0;
        done_c           = 1'b0;
        read_register_c  = '0;
        write_register_c = '0;
        write_data_c     = '0;
        reg_write_c      = 1'b0;
        out_data_c       = '0;
        out_valid_c      = 1'b0;
        in_ready_c       = 1'b0;
        case (state_q)
            ST_SAVE: begin
                busy_c          = 1'b1;
                read_register_c = idx_q;
                out_data_c      = bus.ReadData;
                out_valid_c     = 1'b1;
            end
            ST_RESTORE: begin
                busy_c           = 1'b1;
                in_ready_c       = 1'b1;
                reg_write_c      = bus.InValid;
                write_register_c = idx_q;
                write_data_c     = bus.InData;
            end
            ST_DONE: begin
                done_c = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.Busy          = busy_c;
    assign bus.Done          = done_c;
    assign bus.ReadRegister  = read_register_c;
    assign bus.WriteRegister = write_register_c;
    assign bus.WriteData     = write_data_c;
    assign bus.RegWrite      = reg_write_c;
    assign bus.OutData       = out_data_c;
    assign bus.OutValid      = out_valid_c;
    assign bus.InReady       = in_ready_c;

endmodule

// File: tb/tb_regfile_context_engine.sv
// Testbench for regfile_context_engine: a behavioural register file plus
// scoreboard queues of expected save beats and restore writes.
module tb_regfile_context_engine;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] rf [32];
    logic        preload_en;
    logic [31:0] preload_base;

    logic [31:0] save_q [$];
    wr_t         wr_q   [$];

    regfile_context_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile_context_engine #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .FIRST_REG (1),
        .LAST_REG  (31)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational read port of the bench register file
    assign bus.ReadData = rf[bus.ReadRegister];

    // Register file: bulk preload or a single write per edge, r0 hardwired zero
    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= (i == 0) ? 32'h0 : preload_base + 32'(i);
            end
        end else if (bus.RegWrite && bus.WriteRegister != 5'd0) begin
            rf[bus.WriteRegister] <= bus.WriteData;
        end
    end

    task automatic preload(input logic [31:0] base);
        @(negedge clk);
        preload_base = base;
        preload_en   = 1'b1;
        @(negedge clk);
        preload_en   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.SaveStart = 1'b1;
        bus.RestoreStart = 1'b1;
        bus.InValid = 1'b1;
        #1;
        total++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.OutValid !== 1'b0 ||
            bus.InReady !== 1'b0 || bus.RegWrite !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy=%b done=%b ov=%b ir=%b rw=%b, required all 0",
                     bus.Busy, bus.Done, bus.OutValid, bus.InReady, bus.RegWrite);
        end
        total++;
        if (bus.ReadRegister !== 5'd0 || bus.WriteRegister !== 5'd0 ||
            bus.OutData !== 32'd0 || bus.WriteData !== 32'd0) begin
            bad++;
            $display("FAIL reset_bus: ra=%0d wa=%0d od=%h wd=%h, required all 0",
                     bus.ReadRegister, bus.WriteRegister, bus.OutData, bus.WriteData);
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: busy=%b required 0 while reset held", bus.Busy);
        end
        bus.SaveStart = 1'b0;
        bus.RestoreStart = 1'b0;
        bus.InValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("reset: released");
    endtask

    task automatic test_save_full();
        logic [31:0] exp;
        preload(32'h100);
        save_q.delete();
        for (int i = 1; i <= 31; i++) save_q.push_back(32'h100 + 32'(i));
        @(negedge clk);
        bus.SaveStart = 1'b1;
        bus.OutReady  = 1'b1;
        @(negedge clk);
        bus.SaveStart = 1'b0;
        for (int c = 0; c < 33; c++) begin
            #1;
            if (c < 31) begin
                exp = (save_q.size() != 0) ? save_q.pop_front() : 32'hDEAD_BEEF;
                total++;
                if (bus.OutValid !== 1'b1 || bus.OutData !== exp) begin
                    bad++;
                    $display("FAIL save_beat: cycle %0d valid=%b data=%h, required valid=1 data=%h",
                             c, bus.OutValid, bus.OutData, exp);
                end
                total++;
                if (bus.ReadRegister !== 5'(c + 1)) begin
                    bad++;
                    $display("FAIL save_addr: cycle %0d addr=%0d, required %0d",
                             c, bus.ReadRegister, c + 1);
                end
                $display("save beat: r%0d data=%h", bus.ReadRegister, bus.OutData);
            end else if (c == 31) begin
                total++;
                if (bus.Done !== 1'b1 || bus.OutValid !== 1'b0) begin
                    bad++;
                    $display("FAIL save_done: done=%b ov=%b, required done=1 ov=0",
                             bus.Done, bus.OutValid);
                end
            end else begin
                total++;
                if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
                    bad++;
                    $display("FAIL save_idle: done=%b busy=%b, required 0 0", bus.Done, bus.Busy);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_save_stall();
        int beats = 0;
        int dones = 0;
        int post  = 0;
        logic [31:0] exp;
        preload(32'h200);
        save_q.delete();
        for (int i = 1; i <= 31; i++) save_q.push_back(32'h200 + 32'(i));
        @(negedge clk);
        bus.SaveStart = 1'b1;
        bus.OutReady  = 1'b0;
        @(negedge clk);
        bus.SaveStart = 1'b0;
        for (int c = 0; c < 200; c++) begin
            bus.OutReady = (c % 3 == 0);
            #1;
            if (bus.OutValid === 1'b1) begin
                exp = (save_q.size() != 0) ? save_q[0] : 32'hDEAD_BEEF;
                total++;
                if (bus.OutData !== exp) begin
                    bad++;
                    $display("FAIL stall_data: cycle %0d data=%h, required %h", c, bus.OutData, exp);
                end
                if (bus.OutReady) begin
                    if (save_q.size() != 0) void'(save_q.pop_front());
                    beats++;
                    $display("stall beat: r%0d data=%h", bus.ReadRegister, bus.OutData);
                end
            end
            if (bus.Done === 1'b1) dones++;
            if (dones != 0) post++;
            if (post > 3) break;
            @(negedge clk);
        end
        bus.OutReady = 1'b0;
        total++;
        if (beats != 31 || dones != 1 || save_q.size() != 0) begin
            bad++;
            $display("FAIL stall_count: beats=%0d dones=%0d left=%0d, required 31 1 0",
                     beats, dones, save_q.size());
        end
    endtask

    task automatic test_restore();
        int  k = 1;
        int  dones = 0;
        logic exp_rw;
        wr_t exp;
        preload(32'h300);
        wr_q.delete();
        for (int i = 1; i <= 31; i++) wr_q.push_back({5'(i), 32'hA000 + 32'(i)});
        @(negedge clk);
        bus.RestoreStart = 1'b1;
        bus.InValid = 1'b0;
        @(negedge clk);
        bus.RestoreStart = 1'b0;
        for (int c = 0; c < 200; c++) begin
            bus.InValid = (c % 3 != 2);
            bus.InData  = 32'hA000 + 32'(k);
            #1;
            exp_rw = (wr_q.size() != 0) && bus.InValid;
            total++;
            if (bus.RegWrite !== exp_rw) begin
                bad++;
                $display("FAIL restore_we: cycle %0d rw=%b, required %b", c, bus.RegWrite, exp_rw);
            end
            if (bus.RegWrite === 1'b1 && wr_q.size() != 0) begin
                exp = wr_q.pop_front();
                total++;
                if (bus.WriteRegister !== exp.addr || bus.WriteData !== exp.data ||
                    bus.InReady !== 1'b1) begin
                    bad++;
                    $display("FAIL restore_wr: addr=%0d data=%h ir=%b, required addr=%0d data=%h ir=1",
                             bus.WriteRegister, bus.WriteData, bus.InReady, exp.addr, exp.data);
                end
                $display("restore write: r%0d data=%h", bus.WriteRegister, bus.WriteData);
                k++;
            end
            if (bus.Done === 1'b1) dones++;
            if (dones != 0 && wr_q.size() == 0 && bus.Done === 1'b0) break;
            @(negedge clk);
        end
        bus.InValid = 1'b0;
        @(negedge clk);
        total++;
        if (dones != 1 || wr_q.size() != 0) begin
            bad++;
            $display("FAIL restore_count: dones=%0d left=%0d, required 1 0", dones, wr_q.size());
        end
        for (int i = 0; i < 32; i++) begin
            total++;
            if (rf[i] !== ((i == 0) ? 32'h0 : 32'hA000 + 32'(i))) begin
                bad++;
                $display("FAIL restore_rb: r%0d=%h, required %h", i, rf[i],
                         (i == 0) ? 32'h0 : 32'hA000 + 32'(i));
            end
        end
    endtask

    task automatic test_both_start();
        int dones = 0;
        int restores = 0;
        @(negedge clk);
        bus.SaveStart    = 1'b1;
        bus.RestoreStart = 1'b1;
        bus.OutReady     = 1'b1;
        @(negedge clk);
        bus.SaveStart    = 1'b0;
        bus.RestoreStart = 1'b0;
        #1;
        total++;
        if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b0) begin
            bad++;
            $display("FAIL both_prio: ov=%b ir=%b, required 1 0", bus.OutValid, bus.InReady);
        end
        for (int c = 0; c < 45; c++) begin
            bus.RestoreStart = (c == 3) || (dones != 0 && c < 40 && bus.Busy === 1'b0 && 1'b0);
            #1;
            if (bus.InReady === 1'b1) restores++;
            if (bus.Done === 1'b1) begin
                dones++;
                bus.RestoreStart = 1'b1;
            end
            @(negedge clk);
        end
        bus.RestoreStart = 1'b0;
        bus.OutReady = 1'b0;
        total++;
        if (dones != 1 || restores != 0 || bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL both_ignore: dones=%0d restore_cycles=%0d busy=%b, required 1 0 0",
                     dones, restores, bus.Busy);
        end
        $display("both start: save only, restore request ignored");
    endtask

    task automatic test_reset_mid_save();
        int beats = 0;
        preload(32'h100);
        @(negedge clk);
        bus.SaveStart = 1'b1;
        bus.OutReady  = 1'b1;
        @(negedge clk);
        bus.SaveStart = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.OutValid === 1'b1) beats++;
            if (beats == 10) break;
            @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (beats != 10 || bus.OutValid !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL rst_save: beats=%0d ov=%b busy=%b done=%b, required 10 0 0 0",
                     beats, bus.OutValid, bus.Busy, bus.Done);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.SaveStart = 1'b1;
        @(negedge clk);
        bus.SaveStart = 1'b0;
        #1;
        total++;
        if (bus.ReadRegister !== 5'd1 || bus.OutData !== 32'h101) begin
            bad++;
            $display("FAIL rst_save_restart: addr=%0d data=%h, required 1 00000101",
                     bus.ReadRegister, bus.OutData);
        end
        $display("reset mid save: restart at r%0d data=%h", bus.ReadRegister, bus.OutData);
        bus.OutReady = 1'b0;
        pulse_reset();
    endtask

    task automatic test_reset_mid_restore();
        int k = 1;
        int writes = 0;
        int dones = 0;
        preload(32'h100);
        @(negedge clk);
        bus.RestoreStart = 1'b1;
        bus.InValid = 1'b1;
        bus.InData  = 32'hB001;
        @(negedge clk);
        bus.RestoreStart = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.InData = 32'hB000 + 32'(k);
            #1;
            if (bus.RegWrite === 1'b1) begin
                writes++;
                k++;
            end
            if (bus.Done === 1'b1) dones++;
            if (writes == 5) break;
            @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.Busy !== 1'b0 || bus.RegWrite !== 1'b0 || bus.InReady !== 1'b0 || bus.Done !== 1'b0) begin
            bad++;
            $display("FAIL rst_restore: busy=%b rw=%b ir=%b done=%b, required all 0",
                     bus.Busy, bus.RegWrite, bus.InReady, bus.Done);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.InValid = 1'b0;
        for (int i = 1; i < 32; i++) begin
            total++;
            if (rf[i] !== ((i <= 5) ? 32'hB000 + 32'(i) : 32'h100 + 32'(i))) begin
                bad++;
                $display("FAIL rst_restore_rb: r%0d=%h, required %h", i, rf[i],
                         (i <= 5) ? 32'hB000 + 32'(i) : 32'h100 + 32'(i));
            end
        end
        total++;
        if (dones != 0 || writes != 5) begin
            bad++;
            $display("FAIL rst_restore_done: dones=%0d writes=%0d, required 0 5", dones, writes);
        end
        bus.RestoreStart = 1'b1;
        bus.InValid = 1'b1;
        bus.InData  = 32'hC001;
        @(negedge clk);
        bus.RestoreStart = 1'b0;
        #1;
        total++;
        if (bus.WriteRegister !== 5'd1 || bus.RegWrite !== 1'b1) begin
            bad++;
            $display("FAIL rst_restore_restart: addr=%0d rw=%b, required 1 1",
                     bus.WriteRegister, bus.RegWrite);
        end
        $display("reset mid restore: restart at r%0d", bus.WriteRegister);
        bus.InValid = 1'b0;
        pulse_reset();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        preload_en   = 1'b0;
        preload_base = 32'h0;
        bus.SaveStart    = 1'b0;
        bus.RestoreStart = 1'b0;
        bus.OutReady     = 1'b0;
        bus.InValid      = 1'b0;
        bus.InData       = 32'h0;
        test_reset();
        test_save_full();
        test_save_stall();
        test_restore();
        test_both_start();
        test_reset_mid_save();
        test_reset_mid_restore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
